// File: rtl/button_event_ctrl.sv
// rtl/button_event_ctrl.sv - button event arbiter, auto-repeat FSM and event FIFO; optional release events via BTNCTRL_RELEASE_EN
module button_event_ctrl #(
  parameter int N_BTN      = 5,
  parameter int HOLD_CYC   = 50000000,
  parameter int REPEAT_CYC = 10000000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_dn,
  input  logic [N_BTN-1:0] btn_up,
  input  logic [N_BTN-1:0] btn_lvl,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [2:0]       evt_btn,
  output logic [1:0]       evt_kind,
  output logic             ovf,
  input  logic             ovf_clr
);

  localparam int CNT_MAX = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int CTW     = AW + 1;

  localparam logic [1:0] KIND_PRESS   = 2'd0;
  localparam logic [1:0] KIND_REPEAT  = 2'd1;
  localparam logic [1:0] KIND_RELEASE = 2'd2;

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_REPEAT} state_t;

  // Round-robin search: returns {found, index} of the first set bit at or after ptr, wrapping.
  function automatic logic [3:0] rr_pick(input logic [N_BTN-1:0] req, input logic [2:0] ptr);
    logic [3:0] res;
    logic [3:0] idx;
    res = '0;
    for (int k = N_BTN - 1; k >= 0; k--) begin
      idx = {1'b0, ptr} + 4'(k);
      if (idx >= 4'(N_BTN)) idx = idx - 4'(N_BTN);
      if (req[idx[2:0]]) res = {1'b1, idx[2:0]};
    end
    return res;
  endfunction

  function automatic logic [2:0] rr_next(input logic [2:0] g);
    return (g == 3'(N_BTN - 1)) ? 3'd0 : g + 3'd1;
  endfunction

  logic [N_BTN-1:0] pend;
  logic [2:0]       rr_ptr;
  state_t           state, state_nx;
  logic [2:0]       h, h_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic [4:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CTW-1:0]   count;

  logic       can_push, pop, push, rep_req, grant_p, grant_r, rep_push, rep_drop;
  logic [3:0] p_pick, r_pick;
  logic [4:0] push_data;

  assign can_push  = (count < CTW'(FIFO_DEPTH));
  assign evt_valid = (count != '0);
  assign pop       = evt_valid && evt_ready;
  assign {evt_btn, evt_kind} = evt_valid ? mem[rd_ptr] : 5'd0;

  assign p_pick  = rr_pick(pend, rr_ptr);
  assign grant_p = can_push && p_pick[3];
  assign rep_req = btn_lvl[h] &&
                   (((state == S_HOLD)   && (cnt == CW'(HOLD_CYC - 1))) ||
                    ((state == S_REPEAT) && (cnt == CW'(REPEAT_CYC - 1))));
  // A repeat loses silently to a press grant; it only counts as a drop when the FIFO is full.
  assign rep_push = rep_req && can_push && !grant_p;
  assign rep_drop = rep_req && !can_push;

`ifdef BTNCTRL_RELEASE_EN
  logic [N_BTN-1:0] rel_pend;
  assign r_pick  = rr_pick(rel_pend, rr_ptr);
  assign grant_r = can_push && !p_pick[3] && !rep_req && r_pick[3];

  // Release pending bits: set by btn_up, cleared when the release event is queued.
  always_ff @(posedge clk) begin
    if (!rst_n) rel_pend <= '0;
    else        rel_pend <= (rel_pend & ~(grant_r ? (N_BTN'(1) << r_pick[2:0]) : '0)) | btn_up;
  end
`else
  logic unused_btn_up;
  assign unused_btn_up = ^btn_up;
  assign r_pick  = 4'd0;
  assign grant_r = 1'b0;
`endif

  // Select the single event pushed this cycle: press, then repeat, then release.
  always_comb begin
    push      = grant_p | rep_push | grant_r;
    push_data = {r_pick[2:0], KIND_RELEASE};
    if (grant_p)       push_data = {p_pick[2:0], KIND_PRESS};
    else if (rep_push) push_data = {h, KIND_REPEAT};
  end

  // Press pending bits and round-robin pointer; a new press wins over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend   <= '0;
      rr_ptr <= '0;
    end else begin
      pend <= (pend & ~(grant_p ? (N_BTN'(1) << p_pick[2:0]) : '0)) | btn_dn;
      if (grant_p)      rr_ptr <= rr_next(p_pick[2:0]);
      else if (grant_r) rr_ptr <= rr_next(r_pick[2:0]);
    end
  end

  // Repeat FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      h     <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      h     <= h_nx;
      cnt   <= cnt_nx;
    end
  end

  // Repeat FSM next state: any press grant retargets, release of the held button idles.
  always_comb begin
    state_nx = state;
    h_nx     = h;
    cnt_nx   = cnt;
    if (grant_p) begin
      state_nx = S_HOLD;
      h_nx     = p_pick[2:0];
      cnt_nx   = '0;
    end else begin
      case (state)
        S_HOLD: begin
          if (!btn_lvl[h]) begin
            state_nx = S_IDLE;
            cnt_nx   = '0;
          end else if (cnt == CW'(HOLD_CYC - 1)) begin
            state_nx = S_REPEAT;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
        S_REPEAT: begin
          if (!btn_lvl[h]) begin
            state_nx = S_IDLE;
            cnt_nx   = '0;
          end else if (cnt == CW'(REPEAT_CYC - 1)) begin
            cnt_nx = '0;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
        default: begin
          state_nx = S_IDLE;
          cnt_nx   = '0;
        end
      endcase
    end
  end

  // FIFO storage; contents need no reset because the head is masked while empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow flag; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk) begin
    if (!rst_n)        ovf <= 1'b0;
    else if (rep_drop) ovf <= 1'b1;
    else if (ovf_clr)  ovf <= 1'b0;
  end

endmodule

// File: tb/tb_button_event_ctrl.sv
// tb/tb_button_event_ctrl.sv - self-checking bench for button_event_ctrl against an event-level model
module tb_button_event_ctrl;

  localparam int N     = 5;
  localparam int HOLD  = 20;
  localparam int REP   = 5;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] btn_dn, btn_up, btn_lvl;
  logic         evt_valid, evt_ready;
  logic [2:0]   evt_btn;
  logic [1:0]   evt_kind;
  logic         ovf, ovf_clr;

  button_event_ctrl #(.N_BTN(N), .HOLD_CYC(HOLD), .REPEAT_CYC(REP), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .btn_dn(btn_dn), .btn_up(btn_up), .btn_lvl(btn_lvl),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_btn(evt_btn), .evt_kind(evt_kind),
    .ovf(ovf), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: events encoded as btn*4 + kind.
  bit [N-1:0] m_pend;
  int         m_rr;
  bit         m_active;
  int         m_h;
  int         m_t;      // cycles since the held button was granted
  bit         m_ovf;
  int         q[$];
  int         log_q[$]; // events the DUT handed over

  task automatic check_val(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Repeat schedule: first at HOLD cycles after grant, then every REP cycles.
  function automatic bit repeat_due(input int t);
    return (t == HOLD - 1) || (t >= HOLD && ((t - HOLD) % REP) == REP - 1);
  endfunction

  task automatic model_step();
    int  g;
    bit  can, req, ovf_set;
    if (!rst_n) begin
      m_pend = '0; m_rr = 0; m_active = 0; m_h = 0; m_t = 0; m_ovf = 0;
      q.delete();
      return;
    end
    can = (q.size() < DEPTH);
    g = -1;
    if (can) begin
      for (int k = 0; k < N; k++) begin
        if (g < 0 && m_pend[(m_rr + k) % N]) g = (m_rr + k) % N;
      end
    end
    req = m_active && btn_lvl[m_h] && repeat_due(m_t);
    ovf_set = 0;
    if (q.size() != 0 && evt_ready) void'(q.pop_front());
    if (g >= 0) begin
      q.push_back(g * 4);
      m_pend[g] = 1'b0;
      m_rr = (g + 1) % N;
      m_active = 1; m_h = g; m_t = 0;
    end else begin
      if (req) begin
        if (can) q.push_back(m_h * 4 + 1);
        else     ovf_set = 1;
      end
      if (m_active && !btn_lvl[m_h]) m_active = 0;
      else if (m_active)             m_t++;
    end
    m_pend = m_pend | btn_dn;
    if (ovf_set)      m_ovf = 1;
    else if (ovf_clr) m_ovf = 0;
  endtask

  task automatic tick();
    if (rst_n && evt_valid && evt_ready) log_q.push_back({evt_btn, evt_kind});
    @(posedge clk);
    model_step();
    #1;
    check_val("valid", evt_valid, (q.size() != 0) ? 1 : 0);
    check_val("ovf", ovf, m_ovf);
    if (q.size() != 0) check_val("head", {evt_btn, evt_kind}, q[0]);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; tick(); rst_n = 1'b1;
  endtask

  int cnt_a, cnt_b;
  bit seen4;

  initial begin
    rst_n = 1'b0; btn_dn = '1; btn_up = '0; btn_lvl = '0; evt_ready = 1'b0; ovf_clr = 1'b0;
    ticks(3);
    check_val("rst_valid", evt_valid, 0);
    check_val("rst_ovf", ovf, 0);
    check_val("rst_btn", evt_btn, 0);
    check_val("rst_kind", evt_kind, 0);
    rst_n = 1'b1; btn_dn = '0;
    ticks(5);
    check_val("post_rst_empty", evt_valid, 0);

    // Single press with 2-cycle latency.
    evt_ready = 1'b1; log_q.delete();
    btn_dn = 5'b00100; tick(); btn_dn = '0;
    check_val("lat_1", evt_valid, 0);
    tick();
    check_val("lat_2", evt_valid, 1);
    ticks(5);
    check_val("single_n", log_q.size(), 1);
    if (log_q.size() >= 1) check_val("single_evt", log_q[0], 2 * 4);

    // Simultaneous presses arbitrated from rr_ptr=0.
    do_reset();
    evt_ready = 1'b0;
    btn_dn = 5'b10110; tick(); btn_dn = '0;
    ticks(4);
    btn_dn = 5'b00001; tick(); btn_dn = '0;
    ticks(2);
    log_q.delete(); evt_ready = 1'b1;
    ticks(6);
    check_val("simul_n", log_q.size(), 4);
    if (log_q.size() == 4) begin
      check_val("simul_0", log_q[0], 1 * 4);
      check_val("simul_1", log_q[1], 2 * 4);
      check_val("simul_2", log_q[2], 4 * 4);
      check_val("simul_3", log_q[3], 0);
    end

    // Auto-repeat over a 40-cycle hold.
    log_q.delete();
    btn_lvl = 5'b01000; btn_dn = 5'b01000; tick(); btn_dn = '0;
    ticks(39);
    btn_lvl = '0;
    ticks(15);
    cnt_a = 0; cnt_b = 0;
    foreach (log_q[i]) begin
      if (log_q[i] == 3 * 4)     cnt_a++;
      if (log_q[i] == 3 * 4 + 1) cnt_b++;
    end
    check_val("rep_press", cnt_a, 1);
    check_val("rep_count", cnt_b, 4);
    check_val("rep_total", log_q.size(), 5);

    // Backpressure: 6 presses with a full FIFO, then a dropped repeat.
    do_reset();
    evt_ready = 1'b0; btn_lvl = 5'b01000;
    for (int i = 0; i < 6; i++) begin
      btn_dn = N'(1) << (i % N); tick();
    end
    btn_dn = '0;
    ticks(2);
    check_val("bp_valid", evt_valid, 1);
    check_val("bp_ovf0", ovf, 0);
    ticks(25);
    check_val("bp_ovf1", ovf, 1);
    btn_lvl = '0; tick();
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    check_val("bp_ovf_clr", ovf, 0);
    log_q.delete(); evt_ready = 1'b1;
    ticks(12);
    cnt_a = 0;
    foreach (log_q[i]) if (log_q[i] % 4 == 0) cnt_a++;
    check_val("bp_delivered", cnt_a, 6);

    // Retarget from a held btn 1 to btn 4.
    do_reset();
    evt_ready = 1'b1; btn_lvl = 5'b00010;
    btn_dn = 5'b00010; tick(); btn_dn = '0;
    ticks(25);
    log_q.delete();
    btn_lvl = 5'b10010; btn_dn = 5'b10000; tick(); btn_dn = '0;
    ticks(35);
    seen4 = 0; cnt_a = 0; cnt_b = 0;
    foreach (log_q[i]) begin
      if (log_q[i] == 4 * 4) seen4 = 1;
      if (seen4 && log_q[i] == 1 * 4 + 1) cnt_a++;
      if (log_q[i] == 4 * 4 + 1) cnt_b++;
    end
    check_val("ret_seen4", seen4, 1);
    check_val("ret_no_b1", cnt_a, 0);
    check_val("ret_b4_rep", (cnt_b >= 2) ? 1 : 0, 1);
    btn_lvl = '0;

    // Randomized traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      btn_dn    = N'($urandom & $urandom & $urandom & $urandom);
      btn_up    = N'($urandom & $urandom & $urandom);
      btn_lvl   = (btn_lvl | btn_dn) & ~N'($urandom & $urandom & $urandom & $urandom & $urandom);
      evt_ready = ((c / 200) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
      ovf_clr   = ($urandom_range(0, 63) == 0);
      rst_n     = ($urandom_range(0, 1499) != 0);
      tick();
    end
    rst_n = 1'b1; btn_dn = '0; btn_up = '0; btn_lvl = '0; ovf_clr = 1'b0;
    ticks(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
